// File: rtl/div_32bit.sv
// div_32bit: multicycle signed integer divider (restoring, one quotient bit
// per cycle). Quotient truncates toward zero; the remainder takes the
// dividend's sign.
// Optional feature macro: DIV_REMAINDER_EN adds the data_remainder output
// port and its register. Without it the remainder stays internal only.
// Start-to-ready latency is WIDTH+1 edges.
module div_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] mag_b;    // |B|, held for the whole loop
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] quo;      // dividend bits shift out, quotient bits shift in
  logic             sign_q;
  logic             div0;
`ifdef DIV_REMAINDER_EN
  logic             sign_r;
`endif

  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] quo_signed;
  logic             start;

  // Operand magnitudes: invert plus one when negative. Unsigned view makes
  // |most-negative| come out right.
  always_comb begin
    mag_a_in = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    mag_b_in = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
  end

  // One restoring step: shift {rem,quo} left, keep the subtraction if it
  // did not go negative. rem < |B| keeps shifted within WIDTH bits, so
  // bit WIDTH of trial is a clean borrow flag.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, mag_b};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  // Final sign fix on the quotient, with divide-by-zero forcing zero.
  always_comb begin
    quo_signed = sign_q ? (~quo + 1'b1) : quo;
    if (div0) quo_signed = '0;
  end

  // A new division is accepted only when idle or in the ready cycle.
  assign start = ctrl_DIV && (state == IDLE || state == DONE);

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      mag_b          <= '0;
      rem            <= '0;
      quo            <= '0;
      sign_q         <= 1'b0;
      div0           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_r         <= 1'b0;
      data_remainder <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          data_resultRDY <= 1'b0;
          if (start) begin
            quo     <= mag_a_in;
            mag_b   <= mag_b_in;
            rem     <= '0;
            sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div0    <= (data_operandB == '0);
            counter <= '0;
`ifdef DIV_REMAINDER_EN
            sign_r  <= data_operandA[WIDTH-1];
`endif
            state   <= BUSY;
          end else begin
            state   <= IDLE;
          end
        end
        BUSY: begin
          rem     <= rem_nxt;
          quo     <= quo_nxt;
          counter <= counter + 1'b1;
          if (counter == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          // With |B|=0 every step succeeds, so rem ends as |A| and the
          // signed remainder naturally reproduces A.
          data_result    <= quo_signed;
          data_exception <= div0;
          data_resultRDY <= 1'b1;
`ifdef DIV_REMAINDER_EN
          data_remainder <= sign_r ? (~rem + 1'b1) : rem;
`endif
          state          <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32bit.sv
// tb_div_32bit: directed vectors with hand-computed answers. The driver
// pushes expected responses (including the cycle rdy must appear in) into
// a queue; a monitor pops and compares whenever data_resultRDY is high.
// Remainder checks compile in only when DIV_REMAINDER_EN is defined.
module tb_div_32bit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  div_32bit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [31:0] rem;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rdy cycle must match the oldest expectation, on time.
  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_rdy: got rdy=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rdy_cycle", 32'(cyc), 32'(e.cyc));
        chk("result", data_result, e.res);
        chk("exception", {31'b0, data_exception}, {31'b0, e.exc});
`ifdef DIV_REMAINDER_EN
        chk("remainder", data_remainder, e.rem);
`endif
      end
    end
  end

  // Called just after a negedge: start edge is the next posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push,
                       input logic [31:0] res, input logic exc, input logic [31:0] rem,
                       output int e_edge);
    exp_t e;
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    e_edge = cyc + 1;
    if (push) begin
      e.res = res; e.exc = exc; e.rem = rem; e.cyc = e_edge + 33;
      q.push_back(e);
    end
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;   // operands must not matter after start
    data_operandB = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
    @(negedge clock);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic exc, input logic [31:0] rem);
    int e;
    @(negedge clock);
    issue(a, b, 1'b1, res, exc, rem, e);
    drain();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_result"}, data_result, 32'h0);
    chk({tag, "_exception"}, {31'b0, data_exception}, 32'h0);
    chk({tag, "_rdy"}, {31'b0, data_resultRDY}, 32'h0);
`ifdef DIV_REMAINDER_EN
    chk({tag, "_remainder"}, data_remainder, 32'h0);
`endif
  endtask

  initial begin
    int e;
    repeat (3) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Basic signs, divide by zero, overflow, small quotient.
    run(32'd100,       32'd7,          32'd14,         1'b0, 32'd2);
    run(-32'sd100,     32'd7,          32'hFFFF_FFF2,  1'b0, 32'hFFFF_FFFE);
    run(32'd100,       -32'sd7,        32'hFFFF_FFF2,  1'b0, 32'd2);
    run(-32'sd100,     -32'sd7,        32'd14,         1'b0, 32'hFFFF_FFFE);
    run(32'd1234,      32'd0,          32'd0,          1'b1, 32'd1234);
    run(-32'sd1234,    32'd0,          32'd0,          1'b1, 32'hFFFF_FB2E);
    run(32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 32'd0);
    run(32'd7,         32'd100,        32'd0,          1'b0, 32'd7);
    run(32'hFFFF_FFFF, 32'h8000_0000,  32'd0,          1'b0, 32'hFFFF_FFFF);

    // Start during BUSY is ignored; start in DONE chains a new division.
    @(negedge clock);
    issue(32'd100, 32'd7, 1'b1, 32'd14, 1'b0, 32'd2, e);
    while (cyc < e + 4) @(negedge clock);
    issue(32'd9, 32'd3, 1'b0, 32'd0, 1'b0, 32'd0, e);
    e = e - 5;
    while (cyc < e + 33) @(negedge clock);
    issue(32'd9, 32'd3, 1'b1, 32'd3, 1'b0, 32'd0, e);
    drain();

    // Reset mid-division: immediate clear, no rdy afterwards.
    @(negedge clock);
    issue(32'd100, 32'd7, 1'b0, 32'd0, 1'b0, 32'd0, e);
    while (cyc < e + 10) @(posedge clock);
    #2 reset = 1'b1;
    #1 chk_zero("abort");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (45) @(negedge clock);
    run(32'd50, 32'd5, 32'd10, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
